// File: rtl/ad9833_pkg.sv
// Shared types and constants for the AD9833 frequency loader: FSM states,
// waveform codes, FREQ register address prefixes and control-word bit positions.
package ad9833_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_FINISH,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    WAVE_SINE        = 2'b00,
    WAVE_TRIANGLE    = 2'b01,
    WAVE_SQUARE      = 2'b10,
    WAVE_SQUARE_DIV2 = 2'b11
  } wave_e;

  localparam logic [1:0] ADDR_FREQ0 = 2'b01;
  localparam logic [1:0] ADDR_FREQ1 = 2'b10;

  localparam int CTRL_B28     = 13;
  localparam int CTRL_FSELECT = 11;
  localparam int CTRL_OPBITEN = 5;
  localparam int CTRL_DIV2    = 3;
  localparam int CTRL_MODE    = 1;

  typedef struct packed {
    logic [15:0] control;
    logic [15:0] adreg0;
    logic [15:0] adreg1;
  } words_t;

endpackage

// File: rtl/ad9833_word_build.sv
// Combinational map of (freq, fsel, wave) to the control word and the two
// 14-bit halves of the tuning word, each tagged with its FREQ register prefix.
module ad9833_word_build
  import ad9833_pkg::*;
(
  input  logic [27:0] freq,
  input  logic        fsel,
  input  logic [1:0]  wave,
  output words_t      words
);

  logic [15:0] ctrl;
  logic [1:0]  prefix;

  always_comb begin
    ctrl               = '0;
    ctrl[CTRL_B28]     = 1'b1;
    ctrl[CTRL_FSELECT] = fsel;
    case (wave_e'(wave))
      WAVE_TRIANGLE:    ctrl[CTRL_MODE] = 1'b1;
      WAVE_SQUARE: begin
        ctrl[CTRL_OPBITEN] = 1'b1;
        ctrl[CTRL_DIV2]    = 1'b1;
      end
      WAVE_SQUARE_DIV2: ctrl[CTRL_OPBITEN] = 1'b1;
      default:          ;
    endcase
  end

  assign prefix        = fsel ? ADDR_FREQ1 : ADDR_FREQ0;
  assign words.control = ctrl;
  assign words.adreg0  = {prefix, freq[13:0]};
  assign words.adreg1  = {prefix, freq[27:14]};

endmodule

// File: rtl/ad9833_freq_loader.sv
// Accepts one frequency request at a time and hands three AD9833 words to the
// serial stage via a go/good_to_reset_go handshake. Define AD9833_TIMEOUT_EN to build the watchdog.
module ad9833_freq_loader
  import ad9833_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [27:0] req_freq,
  input  logic        req_fsel,
  input  logic [1:0]  req_wave,
  output logic        go,
  output logic [15:0] control,
  output logic [15:0] adreg0,
  output logic [15:0] adreg1,
  input  logic        good_to_reset_go,
  input  logic        send_complete,
  output logic        busy,
  output logic        done,
  output logic        err
);

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e state_q, state_d;
  words_t words_q, words_d, built;
  logic   timeout;

  ad9833_word_build u_word_build (
    .freq  (req_freq),
    .fsel  (req_fsel),
    .wave  (req_wave),
    .words (built)
  );

`ifdef AD9833_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             counting;

  assign counting = (state_q == ST_ISSUE) || (state_q == ST_WAIT_DONE);
  assign timeout  = counting && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = counting ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign err = (state_q == ST_ERR);
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // The serial stage has no reset, so a stale good_to_reset_go blocks new work.
  assign req_ready = (state_q == ST_IDLE) && !good_to_reset_go;
  assign go        = (state_q == ST_ISSUE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FINISH);
  assign control   = words_q.control;
  assign adreg0    = words_q.adreg0;
  assign adreg1    = words_q.adreg1;

  always_comb begin
    state_d = state_q;
    words_d = words_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          state_d = ST_ISSUE;
          words_d = built;
        end
      end
      ST_ISSUE: begin
        if (timeout)               state_d = ST_ERR;
        else if (good_to_reset_go) state_d = send_complete ? ST_FINISH : ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (timeout)            state_d = ST_ERR;
        else if (send_complete) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_ERR:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
    end
  end

endmodule

// File: doc/ad9833_freq_loader.md
AD9833_FREQ_LOADER -- requirements
Module: ad9833_freq_loader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 65535: watchdog limit in clk cycles while a transfer is outstanding.
REQ-002 clk  input  1  sole clock; all logic on posedge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  a frequency request is present.
REQ-005 req_ready  output  1  loader can accept a request.
REQ-006 req_freq  input  28  frequency tuning word.
REQ-007 req_fsel  input  1  target register: 0 = FREQ0, 1 = FREQ1.
REQ-008 req_wave  input  2  waveform: 00 sine, 01 triangle, 10 square, 11 square/2.
REQ-009 go  output  1  start strobe to the serial interface stage.
REQ-010 control, adreg0, adreg1  output  16 each  words for the serial interface stage.
REQ-011 good_to_reset_go  input  1  serial stage has taken go.
REQ-012 send_complete  input  1  one-cycle pulse: three words shifted out.
REQ-013 busy  output  1  request outstanding.
REQ-014 done  output  1  one-cycle pulse on successful load.
REQ-015 err  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-016 States: IDLE, ISSUE, WAIT_DONE, FINISH, ERR.
REQ-017 IDLE: req_ready = 1 only when good_to_reset_go = 0. A handshake (req_valid & req_ready) registers all three words and moves to ISSUE.
REQ-018 control = 0x2000 | req_fsel<<11 | wave bits. Wave bits: sine 0x0000, triangle 0x0002, square 0x0028, square/2 0x0020.
REQ-019 Address prefix: 2'b01 for FREQ0, 2'b10 for FREQ1.
REQ-020 adreg0 = {prefix, req_freq[13:0]}. adreg1 = {prefix, req_freq[27:14]}.
REQ-021 Words stay stable from the cycle after acceptance until return to IDLE. They are never changed while busy.
REQ-022 ISSUE: go = 1. Move to WAIT_DONE on the cycle good_to_reset_go is sampled high. go is 0 from the following cycle.
REQ-023 WAIT_DONE: go = 0. Move to FINISH when send_complete is sampled high.
REQ-024 A send_complete arriving in the same cycle as the ISSUE→WAIT_DONE transition is honoured: go directly to FINISH.
REQ-025 FINISH: done = 1 for exactly one cycle, then IDLE.
REQ-026 busy = 1 in every state except IDLE.
REQ-027 req_valid is ignored outside IDLE; no queuing.
REQ-028 send_complete or good_to_reset_go pulses seen in IDLE are ignored.
REQ-029 Latency: go rises 1 cycle after the accepting edge.

Reset
REQ-030 While rst = 1: state IDLE, go = 0, done = 0, err = 0, busy = 0, words = 0x0000, watchdog counter = 0.
REQ-031 Reset mid-transfer aborts to IDLE with no done/err pulse.
REQ-032 After reset, req_ready stays low until good_to_reset_go is low, because the serial stage itself has no reset.

Configuration
REQ-033 Macro AD9833_TIMEOUT_EN defined: a counter runs in ISSUE and WAIT_DONE and clears on entry to IDLE.
REQ-034 When the counter reaches TIMEOUT_CYCLES, the block enters ERR: err = 1 for one cycle, go = 0, then IDLE.
REQ-035 Timeout has priority over a same-cycle send_complete.
REQ-036 Macro not defined: no counter is built, err is tied to 0, and ERR is unreachable.

Structure
REQ-037 Package ad9833_pkg holds:
- state encoding;
- wave codes;
- FREQ0/FREQ1 address prefixes;
- control bit positions (B28, FSELECT, OPBITEN, DIV2, MODE).
REQ-038 One combinational sub-module, ad9833_word_build, maps (freq, fsel, wave) to the three words. The FSM lives in ad9833_freq_loader.

Verification
REQ-039 Sine to FREQ0: freq = 0x1234567, fsel = 0, wave = 00. Expect control = 0x2000, adreg0 = 0x4567, adreg1 = 0x448D, and go high 1 cycle after accept.
REQ-040 Triangle to FREQ1: freq = 0x1234567, fsel = 1, wave = 01. Expect control = 0x2802, adreg0 = 0x8567, adreg1 = 0x848D. Square (wave = 10, fsel = 0): control = 0x2028.
REQ-041 Handshake against a serial-stage model: go falls the cycle after good_to_reset_go is sampled high. One done pulse on send_complete. req_ready returns only after good_to_reset_go is low.
REQ-042 Back-to-back: second req_valid held while busy is not accepted until IDLE. Words are unchanged during the first transfer.
REQ-043 rst asserted in WAIT_DONE: IDLE next cycle, all outputs 0, no done. With good_to_reset_go held high, req_ready stays 0.
REQ-044 With AD9833_TIMEOUT_EN and TIMEOUT_CYCLES = 100, never pulse send_complete. Expect err once at cycle 100 of the transfer, then IDLE. Without the macro, err stays 0 and busy stays 1.
